// File: rtl/test_monitor_pkg.sv
// Shared encodings for the riscv_test_monitor block: per-hart and global run states
// and the tohost value that signals a passing test.
package test_monitor_pkg;

  typedef enum logic [1:0] {
    HART_RUN  = 2'd0,
    HART_PASS = 2'd1,
    HART_FAIL = 2'd2
  } hart_state_e;

  typedef enum logic [1:0] {
    GLB_RUN     = 2'd0,
    GLB_DONE    = 2'd1,
    GLB_TIMEOUT = 2'd2
  } glb_state_e;

  localparam int unsigned PASS_CODE = 1;

endpackage

// File: rtl/test_monitor_hart.sv
// One hart's tohost decoder and terminal state; optional self-loop stall detector
// is built only when TEST_MONITOR_STALL_DETECT_EN is defined.
module test_monitor_hart
  import test_monitor_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  TOHOST_ADDR  = 32'h0000_1000
`ifdef TEST_MONITOR_STALL_DETECT_EN
  ,
  parameter int               STALL_CYCLES = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            st_valid_i,
  input  logic [XLEN-1:0] st_addr_i,
  input  logic [XLEN-1:0] st_data_i,
`ifdef TEST_MONITOR_STALL_DETECT_EN
  input  logic            retire_valid_i,
  input  logic [XLEN-1:0] retire_pc_i,
  input  logic [XLEN-1:0] gp_value_i,
`endif
  output logic [1:0]      state_o,
  output logic [XLEN-1:0] code_o
);

  hart_state_e     state_q, state_d;
  logic [XLEN-1:0] code_q, code_d;
  logic            tohost_hit;
  logic            stall_hit;
  logic            stall_pass;
  logic [XLEN-1:0] stall_code;

`ifdef TEST_MONITOR_STALL_DETECT_EN
  localparam int CNT_W = $clog2(STALL_CYCLES + 1);

  logic [CNT_W-1:0] run_q, run_d;
  logic [XLEN-1:0]  pc_q, pc_d;

  // A retire at a new pc restarts the count at one; the pc register itself is data.
  always_comb begin
    run_d     = run_q;
    pc_d      = pc_q;
    stall_hit = 1'b0;
    if (retire_valid_i && state_q == HART_RUN) begin
      pc_d      = retire_pc_i;
      run_d     = (run_q != '0 && retire_pc_i == pc_q) ? run_q + CNT_W'(1) : CNT_W'(1);
      stall_hit = (run_d == CNT_W'(STALL_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) run_q <= '0;
    else     run_q <= run_d;
    pc_q <= pc_d;
  end

  assign stall_pass = (gp_value_i == XLEN'(PASS_CODE));
  assign stall_code = gp_value_i >> 1;
`else
  assign stall_hit  = 1'b0;
  assign stall_pass = 1'b0;
  assign stall_code = '0;
`endif

  // Even tohost values are syscall traffic; only odd values end the test.
  always_comb begin
    tohost_hit = st_valid_i && (st_addr_i == TOHOST_ADDR) && st_data_i[0];
    state_d    = state_q;
    code_d     = code_q;
    if (state_q == HART_RUN) begin
      if (tohost_hit) begin
        state_d = (st_data_i == XLEN'(PASS_CODE)) ? HART_PASS : HART_FAIL;
        code_d  = st_data_i >> 1;
      end else if (stall_hit) begin
        state_d = stall_pass ? HART_PASS : HART_FAIL;
        code_d  = stall_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HART_RUN;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  assign state_o = state_q;
  assign code_o  = code_q;

endmodule

// File: rtl/riscv_test_monitor.sv
// Multi-hart RISC-V test completion monitor: aggregates per-hart tohost verdicts,
// runs the cycle budget. Optional stall detection: TEST_MONITOR_STALL_DETECT_EN.
module riscv_test_monitor
  import test_monitor_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              N_HARTS      = 1,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = 32'h0000_1000,
  parameter int              TIMEOUT      = 5000,
  parameter int              STALL_CYCLES = 16,
  localparam int             FH_W         = (N_HARTS > 1) ? $clog2(N_HARTS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_HARTS-1:0]      st_valid,
  input  logic [N_HARTS*XLEN-1:0] st_addr,
  input  logic [N_HARTS*XLEN-1:0] st_data,
`ifdef TEST_MONITOR_STALL_DETECT_EN
  input  logic [N_HARTS-1:0]      retire_valid,
  input  logic [N_HARTS*XLEN-1:0] retire_pc,
  input  logic [N_HARTS*XLEN-1:0] gp_value,
`endif
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic                    timeout,
  output logic [FH_W-1:0]         fail_hart,
  output logic [XLEN-1:0]         fail_code,
  output logic [31:0]             cycle_count
);

  logic [1:0]      hart_st   [N_HARTS];
  logic [XLEN-1:0] hart_code [N_HARTS];

  for (genvar g = 0; g < N_HARTS; g++) begin : g_hart
    test_monitor_hart #(
      .XLEN         (XLEN),
      .TOHOST_ADDR  (TOHOST_ADDR)
`ifdef TEST_MONITOR_STALL_DETECT_EN
      ,
      .STALL_CYCLES (STALL_CYCLES)
`endif
    ) u_hart (
      .clk            (clk),
      .rst            (rst),
      .st_valid_i     (st_valid[g]),
      .st_addr_i      (st_addr[g*XLEN +: XLEN]),
      .st_data_i      (st_data[g*XLEN +: XLEN]),
`ifdef TEST_MONITOR_STALL_DETECT_EN
      .retire_valid_i (retire_valid[g]),
      .retire_pc_i    (retire_pc[g*XLEN +: XLEN]),
      .gp_value_i     (gp_value[g*XLEN +: XLEN]),
`endif
      .state_o        (hart_st[g]),
      .code_o         (hart_code[g])
    );
  end

  logic            all_term;
  logic            any_fail;
  logic            run_found;
  logic [FH_W-1:0] fail_idx;
  logic [FH_W-1:0] run_idx;
  logic [XLEN-1:0] fail_cd;
  logic            timeout_hit;

  glb_state_e      glb_q;
  logic [31:0]     cycle_q, cycle_d;
  logic            done_q, pass_q, fail_q, timeout_q;
  logic [FH_W-1:0] fail_hart_q;
  logic [XLEN-1:0] fail_code_q;

  // Lowest-index scan: first failing hart for DONE, first running hart for TIMEOUT.
  always_comb begin
    all_term  = 1'b1;
    any_fail  = 1'b0;
    run_found = 1'b0;
    fail_idx  = '0;
    run_idx   = '0;
    fail_cd   = '0;
    for (int h = 0; h < N_HARTS; h++) begin
      if (hart_st[h] == HART_RUN) begin
        all_term = 1'b0;
        if (!run_found) begin
          run_found = 1'b1;
          run_idx   = FH_W'(h);
        end
      end
      if (hart_st[h] == HART_FAIL && !any_fail) begin
        any_fail = 1'b1;
        fail_idx = FH_W'(h);
        fail_cd  = hart_code[h];
      end
    end
  end

  assign cycle_d     = (cycle_q == 32'hFFFF_FFFF) ? cycle_q : cycle_q + 32'd1;
  assign timeout_hit = ({1'b0, cycle_q} >= 33'(TIMEOUT));

  // Termination is checked before the budget so a tie resolves to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      glb_q       <= GLB_RUN;
      cycle_q     <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_hart_q <= '0;
      fail_code_q <= '0;
    end else if (glb_q == GLB_RUN) begin
      cycle_q <= cycle_d;
      if (all_term) begin
        glb_q       <= GLB_DONE;
        done_q      <= 1'b1;
        pass_q      <= !any_fail;
        fail_q      <= any_fail;
        fail_hart_q <= any_fail ? fail_idx : '0;
        fail_code_q <= any_fail ? fail_cd : '0;
      end else if (timeout_hit) begin
        glb_q       <= GLB_TIMEOUT;
        done_q      <= 1'b1;
        fail_q      <= 1'b1;
        timeout_q   <= 1'b1;
        fail_hart_q <= run_idx;
        fail_code_q <= '0;
      end
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign fail_hart   = fail_hart_q;
  assign fail_code   = fail_code_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Testbench for riscv_test_monitor: a one-hart and a two-hart instance checked every
// cycle against an event-level model (termination cycles -> end cycle -> verdict).
module tb_riscv_test_monitor;

  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam int          TMO1   = 200;
  localparam int          TMO2   = 100;
  localparam int          STALL  = 4;
  localparam logic [31:0] LOOP_PC = 32'h8000_0040;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1 = 1'b1, rst2 = 1'b1;
  logic [0:0]  stv1;
  logic [31:0] sta1, std1;
  logic [1:0]  stv2;
  logic [63:0] sta2, std2;
  logic        done1, pass1, fail1, tmo1;
  logic        done2, pass2, fail2, tmo2;
  logic [0:0]  fh1, fh2;
  logic [31:0] fc1, cc1, fc2, cc2;
`ifdef TEST_MONITOR_STALL_DETECT_EN
  logic [0:0]  rv1;
  logic [31:0] rpc1, gp1;
  logic [1:0]  rv2;
  logic [63:0] rpc2, gp2;
`endif

  riscv_test_monitor #(
    .XLEN(32), .N_HARTS(1), .TOHOST_ADDR(TOHOST), .TIMEOUT(TMO1), .STALL_CYCLES(STALL)
  ) u_dut1 (
    .clk(clk), .rst(rst1), .st_valid(stv1), .st_addr(sta1), .st_data(std1),
`ifdef TEST_MONITOR_STALL_DETECT_EN
    .retire_valid(rv1), .retire_pc(rpc1), .gp_value(gp1),
`endif
    .done(done1), .pass(pass1), .fail(fail1), .timeout(tmo1),
    .fail_hart(fh1), .fail_code(fc1), .cycle_count(cc1)
  );

  riscv_test_monitor #(
    .XLEN(32), .N_HARTS(2), .TOHOST_ADDR(TOHOST), .TIMEOUT(TMO2), .STALL_CYCLES(STALL)
  ) u_dut2 (
    .clk(clk), .rst(rst2), .st_valid(stv2), .st_addr(sta2), .st_data(std2),
`ifdef TEST_MONITOR_STALL_DETECT_EN
    .retire_valid(rv2), .retire_pc(rpc2), .gp_value(gp2),
`endif
    .done(done2), .pass(pass2), .fail(fail2), .timeout(tmo2),
    .fail_hart(fh2), .fail_code(fc2), .cycle_count(cc2)
  );

  // Model: which harts have terminated, on which cycle, with what verdict.
  int          sel, nh, tmo, cyc;
  bit          m_term [2];
  int          m_tc   [2];
  bit          m_fail [2];
  logic [31:0] m_code [2];
  int          m_run  [2];
  logic [31:0] m_pc   [2];
  int          n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    stv1 = '0; sta1 = '0; std1 = '0;
    stv2 = '0; sta2 = '0; std2 = '0;
`ifdef TEST_MONITOR_STALL_DETECT_EN
    rv1 = '0; rpc1 = '0; gp1 = '0;
    rv2 = '0; rpc2 = '0; gp2 = '0;
`endif
  endtask

  task automatic terminate(input int h, input logic [31:0] v);
    m_term[h] = 1'b1;
    m_tc[h]   = cyc;
    m_fail[h] = (v != 32'd1);
    m_code[h] = v >> 1;
  endtask

  task automatic store(input int h, input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      stv1[0] = 1'b1; sta1 = a; std1 = d;
    end else begin
      stv2[h] = 1'b1; sta2[h*32 +: 32] = a; std2[h*32 +: 32] = d;
    end
    if (!m_term[h] && a == TOHOST && d[0]) terminate(h, d);
  endtask

`ifdef TEST_MONITOR_STALL_DETECT_EN
  task automatic retire(input int h, input logic [31:0] pc, input logic [31:0] gp);
    if (sel == 0) begin
      rv1[0] = 1'b1; rpc1 = pc; gp1 = gp;
    end else begin
      rv2[h] = 1'b1; rpc2[h*32 +: 32] = pc; gp2[h*32 +: 32] = gp;
    end
    if (!m_term[h]) begin
      m_run[h] = (m_run[h] > 0 && pc == m_pc[h]) ? m_run[h] + 1 : 1;
      m_pc[h]  = pc;
      if (m_run[h] == STALL) terminate(h, gp);
    end
  endtask
`endif

  task automatic check_outputs(input string tag);
    bit          all_t, is_to, e_done, found;
    int          last, endc;
    logic [31:0] e_pass, e_fail, e_to, e_fh, e_fc, e_cc;
    all_t = 1'b1; last = -1; found = 1'b0;
    for (int h = 0; h < nh; h++) begin
      if (!m_term[h]) all_t = 1'b0;
      else if (m_tc[h] > last) last = m_tc[h];
    end
    // A hart terminating on cycle c is seen by the aggregator on cycle c+1.
    if (all_t && last + 1 <= tmo) begin endc = last + 1; is_to = 1'b0; end
    else begin endc = tmo; is_to = 1'b1; end
    e_done = (endc < cyc);
    e_pass = 0; e_fail = 0; e_to = 0; e_fh = 0; e_fc = 0;
    e_cc   = e_done ? 32'(endc + 1) : 32'(cyc);
    if (e_done && !is_to) begin
      for (int h = 0; h < nh; h++)
        if (m_fail[h] && !found) begin found = 1'b1; e_fh = 32'(h); e_fc = m_code[h]; end
      e_fail = found ? 1 : 0;
      e_pass = found ? 0 : 1;
    end else if (e_done) begin
      e_to = 1; e_fail = 1;
      for (int h = 0; h < nh; h++)
        if (!(m_term[h] && m_tc[h] < tmo) && !found) begin found = 1'b1; e_fh = 32'(h); end
    end
    if (sel == 0) begin
      chk({tag, ".done"}, 32'(done1), 32'(e_done));
      chk({tag, ".pass"}, 32'(pass1), e_pass);
      chk({tag, ".fail"}, 32'(fail1), e_fail);
      chk({tag, ".timeout"}, 32'(tmo1), e_to);
      chk({tag, ".fail_hart"}, 32'(fh1), e_fh);
      chk({tag, ".fail_code"}, fc1, e_fc);
      chk({tag, ".cycle_count"}, cc1, e_cc);
    end else begin
      chk({tag, ".done"}, 32'(done2), 32'(e_done));
      chk({tag, ".pass"}, 32'(pass2), e_pass);
      chk({tag, ".fail"}, 32'(fail2), e_fail);
      chk({tag, ".timeout"}, 32'(tmo2), e_to);
      chk({tag, ".fail_hart"}, 32'(fh2), e_fh);
      chk({tag, ".fail_code"}, fc2, e_fc);
      chk({tag, ".cycle_count"}, cc2, e_cc);
    end
  endtask

  task automatic do_reset(input int s);
    sel = s;
    nh  = (s == 0) ? 1 : 2;
    tmo = (s == 0) ? TMO1 : TMO2;
    clear_inputs();
    if (s == 0) rst1 = 1'b1; else rst2 = 1'b1;
    @(posedge clk); #1;
    if (s == 0) rst1 = 1'b0; else rst2 = 1'b0;
    cyc = 0;
    for (int h = 0; h < 2; h++) begin
      m_term[h] = 1'b0; m_tc[h] = 0; m_fail[h] = 1'b0; m_code[h] = '0;
      m_run[h] = 0; m_pc[h] = '0;
    end
    check_outputs("reset");
  endtask

  task automatic step_chk(input string tag);
    @(posedge clk); #1;
    cyc++;
    clear_inputs();
    check_outputs(tag);
  endtask

  task automatic run_to(input int target, input string tag);
    for (int i = 0; i < 1000 && cyc < target; i++) step_chk(tag);
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return $urandom & 32'hFFFF_FFFE;
      default: return $urandom | 32'h1;
    endcase
  endfunction

  task automatic random_round(input int s, input string tag);
    int rate;
    do_reset(s);
    rate = $urandom_range(4, 64);
    for (int c = 0; c < tmo + 4; c++) begin
      for (int h = 0; h < nh; h++)
        if ($urandom_range(1, rate) == 1)
          store(h, ($urandom_range(0, 2) != 0) ? TOHOST : ($urandom | 32'h1), rand_data());
      step_chk(tag);
    end
  endtask

  initial begin
    clear_inputs();

    // Single hart: pass store on cycle 10 with syscall/other-address noise before it.
    do_reset(0);
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1) store(0, TOHOST, $urandom & 32'hFFFF_FFFE);
      else store(0, TOHOST ^ (32'h4 << $urandom_range(0, 8)), $urandom | 32'h1);
      step_chk("noise");
    end
    store(0, TOHOST, 32'd1);
    step_chk("pass1");
    step_chk("pass1");
    chk("pass1.done_at_12", 32'(done1), 32'd1);
    chk("pass1.count_at_12", cc1, 32'd12);
    store(0, TOHOST, 32'd7);
    for (int i = 0; i < 4; i++) step_chk("pass1_frozen");
    chk("pass1.frozen", cc1, 32'd12);

    // Single hart fail, then reset 3 cycles later and pass.
    do_reset(0);
    for (int i = 0; i < 3; i++) step_chk("pre_fail");
    store(0, TOHOST, 32'h0000_0007);
    for (int i = 0; i < 3; i++) step_chk("fail7");
    chk("fail7.code", fc1, 32'd3);
    chk("fail7.pass", 32'(pass1), 32'd0);
    for (int i = 0; i < 3; i++) step_chk("post_fail");
    do_reset(0);
    chk("rst_after_fail.count", cc1, 32'd0);
    step_chk("after_rst");
    store(0, TOHOST, 32'd1);
    for (int i = 0; i < 3; i++) step_chk("after_rst_pass");
    chk("after_rst.pass", 32'(pass1), 32'd1);

    for (int r = 0; r < 3; r++) random_round(0, "rand1");

    // Two harts: hart1 only sends even tohost values -> timeout blamed on hart1.
    do_reset(1);
    run_to(5, "to_pre");
    store(0, TOHOST, 32'd1);
    step_chk("to_h0");
    store(1, TOHOST, 32'd4);
    step_chk("to_h1a");
    store(1, TOHOST, 32'd0);
    run_to(TMO2 + 3, "to_wait");
    chk("timeout.flag", 32'(tmo2), 32'd1);
    chk("timeout.fail_hart", 32'(fh2), 32'd1);

    // Last hart passes on the cycle the count reaches the budget: termination wins.
    do_reset(1);
    run_to(20, "tie_pre");
    store(0, TOHOST, 32'd1);
    run_to(TMO2 - 1, "tie_wait");
    store(1, TOHOST, 32'd1);
    run_to(TMO2 + 3, "tie_end");
    chk("tie.pass", 32'(pass2), 32'd1);
    chk("tie.timeout", 32'(tmo2), 32'd0);

    // One cycle later is too late.
    do_reset(1);
    run_to(TMO2, "late_wait");
    store(0, TOHOST, 32'd1);
    store(1, TOHOST, 32'd1);
    run_to(TMO2 + 3, "late_end");
    chk("late.timeout", 32'(tmo2), 32'd1);
    chk("late.fail_hart", 32'(fh2), 32'd0);

    // Both harts fail on the same cycle: lowest index reported.
    do_reset(1);
    run_to(8, "dual_pre");
    store(0, TOHOST, 32'd9);
    store(1, TOHOST, 32'd5);
    for (int i = 0; i < 3; i++) step_chk("dual_fail");
    chk("dual_fail.code", fc2, 32'd4);

    for (int r = 0; r < 4; r++) random_round(1, "rand2");

`ifdef TEST_MONITOR_STALL_DETECT_EN
    do_reset(0);
    for (int i = 0; i < STALL; i++) begin retire(0, LOOP_PC, 32'd1); step_chk("stall_pass"); end
    for (int i = 0; i < 3; i++) step_chk("stall_pass_end");
    chk("stall.pass", 32'(pass1), 32'd1);

    do_reset(0);
    retire(0, LOOP_PC, 32'd5); step_chk("stall_f");
    retire(0, LOOP_PC, 32'd5); step_chk("stall_f");
    retire(0, LOOP_PC + 32'd4, 32'd5); step_chk("stall_f");
    for (int i = 0; i < STALL; i++) begin retire(0, LOOP_PC, 32'd5); step_chk("stall_f"); end
    for (int i = 0; i < 3; i++) step_chk("stall_f_end");
    chk("stall.fail_code", fc1, 32'd2);

    do_reset(0);
    for (int i = 0; i < STALL - 1; i++) begin retire(0, LOOP_PC, 32'd1); step_chk("prec"); end
    store(0, TOHOST, 32'd7);
    retire(0, LOOP_PC, 32'd1);
    for (int i = 0; i < 4; i++) step_chk("prec_end");
    chk("prec.fail_code", fc1, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
